demux_bus_1_2: RTL and testbench
================================

DEMUX_BUS_1_2 -- requirements
Module: demux_bus_1_2

Interface
REQ-001 Parameter BUS_WIDTH, default 32, data width of input and both output channels.
REQ-002 Parameter CNT_WIDTH, default 16, width of each per-channel transfer counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high, sampled on posedge clk.
REQ-005 in_data  input  BUS_WIDTH  word offered for routing.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 s  input  1  route select, sampled with in_data: 0 routes to channel A, 1 routes to channel B.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_a / out_b  output  BUS_WIDTH  channel A / B data.
REQ-010 out_a_valid / out_b_valid  output  1  channel A / B holds a valid word.
REQ-011 out_a_ready / out_b_ready  input  1  downstream consumer of A / B takes the word this cycle.
REQ-012 cnt_a / cnt_b  output  CNT_WIDTH  number of words accepted into A / B since reset, modulo 2^CNT_WIDTH.

Function
REQ-013 Input transfer occurs in a cycle where in_valid=1 and in_ready=1; output transfer on X occurs where out_X_valid=1 and out_X_ready=1.
REQ-014 Each channel SHALL hold a one-entry register (data + valid); latency from input transfer to out_X_valid=1 SHALL be exactly 1 cycle.
REQ-015 in_ready SHALL be combinational: s=0 -> (!out_a_valid || out_a_ready); s=1 -> (!out_b_valid || out_b_ready); forced 0 while rst=1.
REQ-016 in_ready SHALL NOT depend on in_valid.
REQ-017 On input transfer with s=0: out_a <= in_data, out_a_valid <= 1, cnt_a <= cnt_a+1; channel B register and cnt_b unchanged. Symmetric for s=1.
REQ-018 Output transfer on X without a same-cycle load into X: out_X_valid <= 0; out_X retains its last value.
REQ-019 Same-cycle output transfer and load on X: out_X <= new word, out_X_valid stays 1 (no bubble, no loss).
REQ-020 While out_X_valid=1 and out_X_ready=0, out_X SHALL remain stable and no load into X occurs.
REQ-021 Channels SHALL be independent: a stalled channel SHALL NOT block transfers routed to, or drained from, the other channel.
REQ-022 out_X_ready while out_X_valid=0 SHALL have no effect.
REQ-023 cnt_X SHALL wrap from 2^CNT_WIDTH-1 to 0 without a flag; counters count input transfers, not output transfers.
REQ-024 in_data and s are don't-care in cycles without an input transfer; a change of s while in_valid=1 and in_ready=0 is legal and re-evaluates in_ready for the new channel.
REQ-025 No word SHALL ever be duplicated, dropped, or routed to the channel not selected by s at its input transfer.

Reset
REQ-026 While rst=1 at posedge clk: out_a_valid=out_b_valid=0, out_a=out_b=0, cnt_a=cnt_b=0; any same-cycle input transfer attempt is discarded.
REQ-027 Reset mid-operation SHALL discard held words; first input transfer is possible in the first cycle after rst deasserts.

Verification
REQ-028 Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, both valids 0, counters 0, all data 0.
REQ-029 Routing: out_X_ready=1, send 0x11111111 s=0 then 0x22222222 s=1 -> out_a=0x11111111 valid one cycle after first, out_b=0x22222222 one cycle after second; cnt_a=1, cnt_b=1.
REQ-030 Stall/independence: out_a_ready=0, A loaded with 0xAAAA0000; then in_valid=1 s=0 -> in_ready=0, out_a stable; switch s=1 -> in_ready=1, word reaches B while A still holds 0xAAAA0000.
REQ-031 Back-to-back: out_a_ready=1, in_valid=1, s=0 for 8 cycles with data 1..8 -> in_ready=1 every cycle, out_a=1..8 on consecutive cycles, cnt_a=8.
REQ-032 Wrap: CNT_WIDTH=4, 17 transfers to B -> cnt_b=1, cnt_a=0.
REQ-033 Random: random s/data/valid/ready for 10000 cycles with per-channel scoreboard -> in-order, no loss or duplication, counters match scoreboard modulo 2^CNT_WIDTH.

Source files
------------

// File: rtl/demux_bus_1_2.sv
// demux_bus_1_2 -- routes one valid/ready input stream to one of two output
// channels (A, B) chosen per word by s. Each channel is a one-entry register
// slice with its own transfer counter.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_data, in_valid, s       offered word, its valid, route select (0=A, 1=B)
//   in_ready                   combinational: the selected channel can take a word
//   out_a/out_b                channel data
//   out_a_valid/out_b_valid    channel holds a word
//   out_a_ready/out_b_ready    downstream takes the held word this cycle
//   cnt_a/cnt_b                words accepted into each channel, wrapping

// One output channel: a single data+valid slot and an input-transfer counter.
module demux_bus_1_2_chan #(
   parameter int BUS_WIDTH = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,     // input transfer routed here this cycle
   input  logic [BUS_WIDTH-1:0] data,
   input  logic                 ready,    // downstream ready
   output logic [BUS_WIDTH-1:0] q,
   output logic                 q_valid,
   output logic [CNT_WIDTH-1:0] cnt,
   output logic                 room      // slot can accept a word this cycle
);

   // Room when empty, or when the held word leaves in this same cycle, so a
   // full slot with a ready consumer streams without a bubble.
   assign room = !q_valid || ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         q       <= '0;
         q_valid <= 1'b0;
         cnt     <= '0;
      end else if (load) begin
         q       <= data;
         q_valid <= 1'b1;
         cnt     <= cnt + 1'b1;
      end else if (q_valid && ready) begin
         // Drained with nothing behind it: drop valid, keep the stale data.
         q_valid <= 1'b0;
      end
   end

endmodule

module demux_bus_1_2 #(
   parameter int BUS_WIDTH = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BUS_WIDTH-1:0] in_data,
   input  logic                 in_valid,
   input  logic                 s,
   output logic                 in_ready,
   output logic [BUS_WIDTH-1:0] out_a,
   output logic                 out_a_valid,
   input  logic                 out_a_ready,
   output logic [BUS_WIDTH-1:0] out_b,
   output logic                 out_b_valid,
   input  logic                 out_b_ready,
   output logic [CNT_WIDTH-1:0] cnt_a,
   output logic [CNT_WIDTH-1:0] cnt_b
);

   localparam int NUM_CH = 2;

   logic [NUM_CH-1:0]                ch_load;
   logic [NUM_CH-1:0]                ch_ready;
   logic [NUM_CH-1:0]                ch_room;
   logic [NUM_CH-1:0]                ch_valid;
   logic [NUM_CH-1:0][BUS_WIDTH-1:0] ch_q;
   logic [NUM_CH-1:0][CNT_WIDTH-1:0] ch_cnt;

   assign ch_ready = {out_b_ready, out_a_ready};

   // Only the selected channel's room matters; in_valid is deliberately not
   // part of this so the handshake has no valid->ready path.
   assign in_ready = !rst && ch_room[s];

   genvar i;
   generate
      for (i = 0; i < NUM_CH; i++) begin : g_ch
         assign ch_load[i] = in_valid && in_ready && (s == 1'(i));

         demux_bus_1_2_chan #(
            .BUS_WIDTH (BUS_WIDTH),
            .CNT_WIDTH (CNT_WIDTH)
         ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .load    (ch_load[i]),
            .data    (in_data),
            .ready   (ch_ready[i]),
            .q       (ch_q[i]),
            .q_valid (ch_valid[i]),
            .cnt     (ch_cnt[i]),
            .room    (ch_room[i])
         );
      end
   endgenerate

   assign out_a       = ch_q[0];
   assign out_b       = ch_q[1];
   assign out_a_valid = ch_valid[0];
   assign out_b_valid = ch_valid[1];
   assign cnt_a       = ch_cnt[0];
   assign cnt_b       = ch_cnt[1];

endmodule

// File: tb/tb_demux_bus_1_2.sv
module tb_demux_bus_1_2;

   localparam int BW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [BW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          s = 1'b0;
   logic          in_ready;
   logic [BW-1:0] out_a, out_b;
   logic          out_a_valid, out_b_valid;
   logic          out_a_ready = 1'b0, out_b_ready = 1'b0;
   logic [CW-1:0] cnt_a, cnt_b;

   int total = 0;
   int bad   = 0;

   demux_bus_1_2 #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .s(s),
      .in_ready(in_ready),
      .out_a(out_a), .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
      .out_b(out_b), .out_b_valid(out_b_valid), .out_b_ready(out_b_ready),
      .cnt_a(cnt_a), .cnt_b(cnt_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each channel is "holding a word or not"; counters are plain integers
   // reduced modulo 2^CW when compared.
   bit          m_full [2];
   logic [BW-1:0] m_word [2];
   int          m_accepted [2];
   bit          started = 0;

   function automatic bit model_ready();
      bit rdy_sel;
      rdy_sel = s ? out_b_ready : out_a_ready;
      return !rst && (!m_full[s] || rdy_sel);
   endfunction

   always @(posedge clk) begin
      bit take;
      bit rdy [2];
      take = in_valid && model_ready();
      rdy[0] = out_a_ready;
      rdy[1] = out_b_ready;
      started = 1;
      for (int c = 0; c < 2; c++) begin
         if (rst) begin
            m_full[c] = 0; m_word[c] = '0; m_accepted[c] = 0;
         end else if (take && (s == c[0])) begin
            m_full[c] = 1; m_word[c] = in_data; m_accepted[c]++;
         end else if (rdy[c]) begin
            m_full[c] = 0;
         end
      end
   end

   // ---------------- per-channel scoreboard + compare ----------------
   logic [BW-1:0] sb_a [$];
   logic [BW-1:0] sb_b [$];

   always @(negedge clk) begin
      if (started) begin
         chk("in_ready",    in_ready,    model_ready());
         chk("out_a_valid", out_a_valid, m_full[0]);
         chk("out_b_valid", out_b_valid, m_full[1]);
         chk("out_a",       out_a,       m_word[0]);
         chk("out_b",       out_b,       m_word[1]);
         chk("cnt_a",       cnt_a,       64'(m_accepted[0] % (1 << CW)));
         chk("cnt_b",       cnt_b,       64'(m_accepted[1] % (1 << CW)));
         if (rst) begin
            sb_a.delete();
            sb_b.delete();
         end else begin
            if (out_a_valid && out_a_ready) begin
               if (sb_a.size() == 0) chk("sb_a_empty_pop", 1, 0);
               else chk("sb_a_order", out_a, sb_a.pop_front());
            end
            if (out_b_valid && out_b_ready) begin
               if (sb_b.size() == 0) chk("sb_b_empty_pop", 1, 0);
               else chk("sb_b_order", out_b, sb_b.pop_front());
            end
            if (in_valid && model_ready()) begin
               if (s) sb_b.push_back(in_data);
               else   sb_a.push_back(in_data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      // Reset held two cycles with a pending word offered.
      rst = 1'b1; in_valid = 1'b1; s = 1'b0; in_data = 32'hDEADBEEF;
      out_a_ready = 1'b1; out_b_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         @(negedge clk);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_valids", {out_a_valid, out_b_valid}, 0);
         chk("rst_data", {out_a, out_b}, 0);
         chk("rst_cnts", {cnt_a, cnt_b}, 0);
      end
      step();

      // Routing: A then B.
      rst = 1'b0; in_valid = 1'b1; s = 1'b0; in_data = 32'h11111111;
      @(negedge clk); chk("route_rdy_a", in_ready, 1);
      step();
      s = 1'b1; in_data = 32'h22222222;
      @(negedge clk);
      chk("route_out_a", out_a, 32'h11111111);
      chk("route_va", out_a_valid, 1);
      chk("route_vb", out_b_valid, 0);
      chk("route_cnt_a", cnt_a, 1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("route_out_b", out_b, 32'h22222222);
      chk("route_vb2", out_b_valid, 1);
      chk("route_cnt_b", cnt_b, 1);
      chk("route_va_drained", out_a_valid, 0);

      // Stall on A must not block B.
      step();
      out_a_ready = 1'b0; in_valid = 1'b1; s = 1'b0; in_data = 32'hAAAA0000;
      step();
      in_data = 32'h12345678;
      @(negedge clk);
      chk("stall_rdy0", in_ready, 0);
      chk("stall_hold", out_a, 32'hAAAA0000);
      step();
      @(negedge clk);
      chk("stall_hold2", out_a, 32'hAAAA0000);
      s = 1'b1; in_data = 32'hBBBB5555;
      #1 chk("stall_switch_rdy", in_ready, 1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("stall_b_data", out_b, 32'hBBBB5555);
      chk("stall_a_still", {out_a_valid, out_a}, {1'b1, 32'hAAAA0000});
      step();
      out_a_ready = 1'b1;
      step();

      // Back-to-back into A after a fresh reset.
      do_reset();
      in_valid = 1'b1; s = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         in_data = k;
         @(negedge clk);
         chk("b2b_rdy", in_ready, 1);
         if (k > 1) chk("b2b_out", out_a, k - 1);
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_last", out_a, 8);
      chk("b2b_cnt", cnt_a, 8);
      step();

      // Counter wrap: 17 words into B with a 4-bit counter.
      do_reset();
      in_valid = 1'b1; s = 1'b1;
      for (int k = 0; k < 17; k++) begin
         in_data = 32'hB000_0000 + k;
         step();
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("wrap_cnt_b", cnt_b, 1);
      chk("wrap_cnt_a", cnt_a, 0);
      step();

      // Random traffic; rare mid-stream resets.
      for (int k = 0; k < 10000; k++) begin
         rst         = ($urandom_range(0, 1999) == 0);
         in_valid    = ($urandom_range(0, 3) != 0);
         s           = 1'($urandom);
         in_data     = $urandom;
         out_a_ready = ($urandom_range(0, 2) != 0);
         out_b_ready = ($urandom_range(0, 3) == 0);
         step();
      end
      rst = 1'b0; in_valid = 1'b0; out_a_ready = 1'b1; out_b_ready = 1'b1;
      repeat (3) step();
      @(negedge clk);
      chk("final_sb_a_empty", sb_a.size(), 0);
      chk("final_sb_b_empty", sb_b.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
